wheel_display: RTL and testbench
================================

# wheel_display

Consumer of the spinner wheel's output. Drives the eight LEDs from the wheel's position while it runs. Latches the stopped position when `running` falls and compares it with the player's guess. Flashes a win or loss pattern paced by the shared tick strobe, then holds it, and keeps a saturating win score. It sits between `wheel` (`pos_o`/`running_o`) and the LED pins, on the same clock and tick strobe.

## Interface
- `BLINK_TICKS`, default 4: tick strobes per blink half-period (≥1).
- `BLINK_HALVES`, default 6: number of half-periods blinked before holding steady (≥1).
- `clk_i`  in  1  system clock (50 MHz).
- `rst_i`  in  1  reset, asynchronous, active-high.
- `tick_i`  in  1  one-clock-wide tick strobe, same strobe that feeds `wheel`.
- `pos_i`  in  3  wheel position (`wheel.pos_o`).
- `running_i`  in  1  wheel running flag (`wheel.running_o`).
- `guess_i`  in  3  player's guessed position, sampled at the stop edge.
- `score_clr_i`  in  1  synchronous clear of `score_o`.
- `led_o`  out  8  LED drive, bit n = position n.
- `result_valid_o`  out  1  high while a latched result is shown.
- `result_pos_o`  out  3  latched stop position.
- `win_o`  out  1  latched result == guess.
- `score_o`  out  8  saturating win count.

## Operation
- `running_q` is a registered copy of `running_i`.
  - rise = `running_i & ~running_q`
  - fall = `~running_i & running_q`
- FSM states: IDLE, SPIN, SHOW, HOLD. Reset state is IDLE.
- **IDLE**: `led_o` = 0.
  - rise → SPIN.
- **SPIN**: each clock, `led_o` <= 1 << `pos_i`.
  - fall → SHOW. On the same edge:
    - `result_pos_o` <= `pos_i`
    - `win_o` <= (`pos_i` == `guess_i`)
    - `result_valid_o` <= 1
    - `score_o` += 1 if win, saturating at 255
    - `tick_cnt` <= 0, `half_cnt` <= 0, `phase` <= 1
- Pattern: 8'hFF if `win_o`, else 1 << `result_pos_o`.
- **SHOW**: `led_o` = pattern when `phase` = 1, else 0.
  - Each `tick_i`: `tick_cnt`++.
  - When `tick_cnt` == BLINK_TICKS−1 and `tick_i`:
    - `tick_cnt` <= 0, `phase` toggles, `half_cnt`++.
    - If `half_cnt` == BLINK_HALVES−1: go to HOLD with `phase` forced to 1.
- **HOLD**: `led_o` = pattern, steady.
- Rise in SHOW or HOLD → SPIN, and on that edge `result_valid_o` <= 0 and `win_o` <= 0. `result_pos_o` keeps its last value.
- Rise in SPIN (impossible with a registered edge detector) is ignored. Fall in IDLE/SHOW/HOLD is ignored.
- `score_clr_i` sets `score_o` to 0. If it coincides with a winning fall, the clear wins and the score becomes 0.
- Counter widths: `tick_cnt` is clog2(BLINK_TICKS) bits, `half_cnt` is clog2(BLINK_HALVES) bits, minimum 1 bit each.

## Timing
- Reset values: all outputs 0, `running_q` = 0, state IDLE, counters 0. Reset mid-operation returns to IDLE immediately, asynchronously. If `running_i` is high after reset release, the first clock sees a rise → SPIN.
- SPIN `led_o` lags `pos_i` by one clock.
- Stop latency: the fall is detected on the first clock with `running_i` = 0. `result_*`, `win_o` and `score_o` update on that same edge. `led_o` shows the pattern (`phase` = 1) from the next cycle.
- A `tick_i` coinciding with the fall edge is not counted. Counting starts with the first tick after entry to SHOW.
- Phase 1 shows for BLINK_TICKS ticks, then the LEDs toggle.
- HOLD is entered on the tick that ends half-period BLINK_HALVES. With the defaults this is the 24th tick after entry.
- BLINK_HALVES even: the last half-period is dark and HOLD turns the LEDs on. BLINK_HALVES odd: the last half-period is lit and stays lit.
- No output changes between ticks in SHOW/HOLD except on a rise.

## Test plan
- Reset held with `running_i` = 1, then released → `led_o`=0, `score_o`=0 during reset; SPIN one clock after release; `led_o` tracks 1<<`pos_i` with one-clock lag.
- Wheel stops at 5 with `guess_i`=5 → `result_pos_o`=5, `win_o`=1, `score_o`=1, `result_valid_o`=1; `led_o`=8'hFF for 4 ticks, 0 for 4 ticks (×3), then steady 8'hFF from tick 24.
- Wheel stops at 2 with `guess_i`=7 → `win_o`=0, score unchanged; `led_o` blinks 8'h04 and holds 8'h04.
- Restart (`running_i` rises) during SHOW blink → next clock SPIN, `result_valid_o`=0, `win_o`=0, `result_pos_o` unchanged; blink counters restart on the next stop.
- 256 consecutive wins → `score_o` saturates at 255. `score_clr_i` coincident with a winning stop → `score_o`=0.
- Fall coincident with `tick_i`, plus `rst_i` asserted mid-SHOW → that tick not counted (HOLD still at the 24th later tick); reset forces all outputs to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/wheel_display.sv
// ---------------------------------------------------------------------------
// wheel_display
//   Drives eight LEDs from the spinner wheel. While the wheel runs, the LED for
//   the current position is lit. When the wheel stops, the module latches the
//   stop position and compares it with the player's guess. It then blinks a
//   win pattern (all LEDs) or a loss pattern (the stop LED) for a fixed number
//   of half-periods, paced by the shared tick strobe, and then holds that
//   pattern steady. It also keeps a saturating count of wins.
//
// Parameters
//   BLINK_TICKS   tick strobes per blink half-period (>= 1)
//   BLINK_HALVES  half-periods blinked before the pattern holds (>= 1)
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   tick_i          one-clock tick strobe, shared with the wheel
//   pos_i           wheel position
//   running_i       wheel running flag
//   guess_i         player's guess, sampled on the stop edge
//   score_clr_i     synchronous clear of score_o
//   led_o           LED drive, bit n = position n
//   result_valid_o  high while a latched result is shown
//   result_pos_o    latched stop position
//   win_o           latched stop position equals the guess
//   score_o         saturating win count
// ---------------------------------------------------------------------------
module wheel_display #(
  parameter int BLINK_TICKS  = 4,
  parameter int BLINK_HALVES = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic [2:0] pos_i,
  input  logic       running_i,
  input  logic [2:0] guess_i,
  input  logic       score_clr_i,
  output logic [7:0] led_o,
  output logic       result_valid_o,
  output logic [2:0] result_pos_o,
  output logic       win_o,
  output logic [7:0] score_o
);

  localparam int TW = (BLINK_TICKS  > 1) ? $clog2(BLINK_TICKS)  : 1;
  localparam int HW = (BLINK_HALVES > 1) ? $clog2(BLINK_HALVES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_HALVES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_SHOW = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          running_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    led_q, led_d;
  logic          valid_q, valid_d;
  logic [2:0]    result_pos_q, result_pos_d;
  logic          win_q, win_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    pattern_d;
  logic          rise, fall, hit;

  assign rise = running_i & ~running_q;
  assign fall = ~running_i & running_q;
  assign hit  = (pos_i == guess_i);

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    half_cnt_d   = half_cnt_q;
    phase_d      = phase_q;
    valid_d      = valid_q;
    result_pos_d = result_pos_q;
    win_d        = win_q;
    score_d      = score_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_SPIN;
      end
      ST_SPIN: begin
        if (fall) begin
          state_d      = ST_SHOW;
          result_pos_d = pos_i;
          win_d        = hit;
          valid_d      = 1'b1;
          if (hit && (score_q != 8'hFF)) score_d = score_q + 8'd1;
          // Counting restarts here; a tick on this same edge is ignored.
          tick_cnt_d   = '0;
          half_cnt_d   = '0;
          phase_d      = 1'b1;
        end
      end
      ST_SHOW: begin
        if (rise) begin
          state_d = ST_SPIN;
          valid_d = 1'b0;
          win_d   = 1'b0;
        end else if (tick_i) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            phase_d    = ~phase_q;
            half_cnt_d = half_cnt_q + 1'b1;
            // Last half-period finished: settle on the lit pattern.
            if (half_cnt_q == HALF_LAST) begin
              state_d = ST_HOLD;
              phase_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (rise) begin
          state_d = ST_SPIN;
          valid_d = 1'b0;
          win_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear beats a coincident winning stop.
    if (score_clr_i) score_d = 8'd0;

    // LED drive is registered and derived from the next state so that the
    // shown pattern changes on exactly the edge the state does.
    pattern_d = win_d ? 8'hFF : (8'd1 << result_pos_d);
    case (state_d)
      ST_SPIN: led_d = 8'd1 << pos_i;
      ST_SHOW: led_d = phase_d ? pattern_d : 8'd0;
      ST_HOLD: led_d = pattern_d;
      default: led_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      running_q    <= 1'b0;
      tick_cnt_q   <= '0;
      half_cnt_q   <= '0;
      phase_q      <= 1'b0;
      led_q        <= 8'd0;
      valid_q      <= 1'b0;
      result_pos_q <= 3'd0;
      win_q        <= 1'b0;
      score_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      running_q    <= running_i;
      tick_cnt_q   <= tick_cnt_d;
      half_cnt_q   <= half_cnt_d;
      phase_q      <= phase_d;
      led_q        <= led_d;
      valid_q      <= valid_d;
      result_pos_q <= result_pos_d;
      win_q        <= win_d;
      score_q      <= score_d;
    end
  end

  assign led_o          = led_q;
  assign result_valid_o = valid_q;
  assign result_pos_o   = result_pos_q;
  assign win_o          = win_q;
  assign score_o        = score_q;

endmodule

// File: tb/tb_wheel_display.sv
// ---------------------------------------------------------------------------
// tb_wheel_display
//   Bench for wheel_display with default parameters. Each stop pushes the
//   expected {result_pos, win, score} onto a queue; a monitor pops and
//   compares it when result_valid_o rises. LED sequences are checked against
//   the blink timing derived from BLINK_TICKS / BLINK_HALVES.
// ---------------------------------------------------------------------------
module tb_wheel_display;

  localparam int BT = 4;
  localparam int BH = 6;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic [2:0] pos_i = 3'd0;
  logic       running_i = 1'b0;
  logic [2:0] guess_i = 3'd0;
  logic       score_clr_i = 1'b0;
  logic [7:0] led_o;
  logic       result_valid_o;
  logic [2:0] result_pos_o;
  logic       win_o;
  logic [7:0] score_o;

  int n_total = 0;
  int n_bad   = 0;
  logic [11:0] exp_q[$];
  int exp_score = 0;

  wheel_display #(.BLINK_TICKS(BT), .BLINK_HALVES(BH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .pos_i(pos_i),
    .running_i(running_i), .guess_i(guess_i), .score_clr_i(score_clr_i),
    .led_o(led_o), .result_valid_o(result_valid_o), .result_pos_o(result_pos_o),
    .win_o(win_o), .score_o(score_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: result_valid_o rising pops one expected result
  logic valid_prev = 1'b0;
  always @(negedge clk_i) begin
    if (result_valid_o && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check_val("result_pos", 32'(result_pos_o), 32'(e[11:9]));
        check_val("result_win", 32'(win_o), 32'(e[8]));
        check_val("result_score", 32'(score_o), 32'(e[7:0]));
      end
    end
    valid_prev = result_valid_o;
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic restart();
    running_i = 1'b1;
    step();
  endtask

  task automatic do_stop(input logic [2:0] p, input logic [2:0] g,
                         input logic with_tick, input logic with_clr);
    logic w;
    w = (p == g);
    if (with_clr) exp_score = 0;
    else if (w && exp_score < 255) exp_score++;
    exp_q.push_back({p, w, 8'(exp_score)});
    pos_i = p;
    guess_i = g;
    tick_i = with_tick;
    score_clr_i = with_clr;
    running_i = 1'b0;
    step();
    tick_i = 1'b0;
    score_clr_i = 1'b0;
  endtask

  // Called right after the stop edge: checks the full blink then the hold.
  task automatic check_blink(input logic [7:0] pat);
    for (int h = 0; h < BH; h++) begin
      for (int t = 0; t < BT; t++) begin
        check_val($sformatf("blink_h%0d_t%0d", h, t), 32'(led_o), (h % 2 == 0) ? 32'(pat) : 32'd0);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        step();
      end
    end
    for (int k = 0; k < 3; k++) begin
      check_val("hold_led", 32'(led_o), 32'(pat));
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      step();
    end
    check_val("hold_valid", 32'(result_valid_o), 32'd1);
  endtask

  task automatic n_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      step();
    end
  endtask

  initial begin
    logic [2:0] p;
    // reset held with running high
    running_i = 1'b1;
    pos_i = 3'd3;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_led", 32'(led_o), 32'd0);
    check_val("rst_score", 32'(score_o), 32'd0);
    check_val("rst_valid", 32'(result_valid_o), 32'd0);
    rst_i = 1'b0;
    step();
    check_val("spin_first", 32'(led_o), 32'h08);
    for (int i = 0; i < 6; i++) begin
      p = 3'($urandom_range(0, 7));
      pos_i = p;
      step();
      check_val("spin_track", 32'(led_o), 32'(8'd1 << p));
    end

    // win at 5
    do_stop(3'd5, 3'd5, 1'b0, 1'b0);
    check_blink(8'hFF);

    // loss at 2, guess 7
    restart();
    check_val("restart_valid", 32'(result_valid_o), 32'd0);
    check_val("restart_win", 32'(win_o), 32'd0);
    pos_i = 3'd0;
    step();
    do_stop(3'd2, 3'd7, 1'b0, 1'b0);
    check_blink(8'h04);

    // restart mid-blink, then a fresh full blink
    restart();
    do_stop(3'd1, 3'd1, 1'b0, 1'b0);
    n_ticks(5);
    restart();
    check_val("mid_valid", 32'(result_valid_o), 32'd0);
    check_val("mid_win", 32'(win_o), 32'd0);
    check_val("mid_pos_kept", 32'(result_pos_o), 32'd1);
    check_val("mid_led", 32'(led_o), 32'h02);
    do_stop(3'd6, 3'd6, 1'b0, 1'b0);
    check_blink(8'hFF);

    // saturation
    for (int i = 0; i < 256; i++) begin
      restart();
      p = 3'($urandom_range(0, 7));
      do_stop(p, p, 1'b0, 1'b0);
    end
    check_val("score_sat", 32'(score_o), 32'd255);

    // clear coincident with winning stop
    restart();
    do_stop(3'd4, 3'd4, 1'b0, 1'b1);
    check_val("clr_score", 32'(score_o), 32'd0);

    // tick on the stop edge is not counted
    restart();
    do_stop(3'd3, 3'd0, 1'b1, 1'b0);
    check_blink(8'h08);

    // async reset mid-SHOW
    restart();
    do_stop(3'd4, 3'd4, 1'b0, 1'b0);
    n_ticks(6);
    #2;
    rst_i = 1'b1;
    #1;
    check_val("arst_led", 32'(led_o), 32'd0);
    check_val("arst_valid", 32'(result_valid_o), 32'd0);
    check_val("arst_pos", 32'(result_pos_o), 32'd0);
    check_val("arst_win", 32'(win_o), 32'd0);
    check_val("arst_score", 32'(score_o), 32'd0);
    running_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    check_val("post_rst_led", 32'(led_o), 32'd0);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
